// File: rtl/shift_left_logical_seq.sv
// shift_left_logical_seq: multi-cycle logical left shifter.
// One binary shift stage (by 1, 2, 4, ... N/2) is applied per clock, so the
// datapath per cycle is a single 2:1 mux row instead of a full N-way barrel.
// Also reports whether any 1 bit was pushed out past the MSB.
// Valid/ready handshakes on both the operand side and the result side.
module shift_left_logical_seq #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [N-1:0]         out,
  output logic                 lost
);

  localparam int S = $clog2(N);
  localparam logic [S-1:0] last_stage = S'(S - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t         state;
  logic [N-1:0]   acc;
  logic [S-1:0]   sh;
  logic [S-1:0]   stage;

  int             stage_amt;
  logic [N-1:0]   acc_shifted;
  logic           spill;

  // Shift distance of the current stage (2^stage), the shifted accumulator,
  // and whether the top 2^stage bits about to fall off contain any 1.
  always_comb begin
    stage_amt   = 1 << stage;
    acc_shifted = acc << stage_amt;
    spill       = (acc >> (N - stage_amt)) != '0;
  end

  // Handshake flags and result are decoded purely from registered state.
  always_comb begin
    i_ready = (state == IDLE);
    o_valid = (state == DONE);
    out     = acc;
  end

  // Control FSM plus datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      sh    <= '0;
      stage <= '0;
      lost  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            acc   <= in;
            sh    <= shamt;
            stage <= '0;
            lost  <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (sh[stage]) begin
            acc  <= acc_shifted;
            lost <= lost | spill;
          end
          if (stage == last_stage) begin
            state <= DONE;
          end else begin
            stage <= stage + 1'b1;
          end
        end
        DONE: begin
          if (o_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_left_logical_seq.sv
// Testbench for shift_left_logical_seq: directed vector table, backpressure,
// mid-operation reset, and a randomized run against a direct shift model.
module tb_shift_left_logical_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] in;
  logic [4:0]  shamt;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] out;
  logic        lost;

  int vectors     = 0;
  int miscompares = 0;
  int accepts     = 0;
  int results     = 0;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  s;
    logic [31:0] exp_out;
    logic        exp_lost;
  } vec_t;

  vec_t vecs[12];

  shift_left_logical_seq #(.N(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .in      (in),
    .shamt   (shamt),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .out     (out),
    .lost    (lost)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Count operand accepts and result transfers as seen at the clock edge.
  always @(posedge clk) begin
    if (!rst && i_valid && i_ready) accepts++;
    if (!rst && o_valid && o_ready) results++;
  end

  // Hard stop in case the run wedges somewhere unexpected.
  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present an operand, wait (bounded) for i_ready, and let the accept edge pass.
  task automatic applyStimulus(input logic [31:0] a, input logic [4:0] s);
    int w;
    w = 0;
    in      = a;
    shamt   = s;
    i_valid = 1'b1;
    while (!i_ready && w < 20) begin
      tick;
      w++;
    end
    checkOutput("accept_ready", i_ready, 1);
    tick;
    i_valid = 1'b0;
  endtask

  // Called just after the accept edge; counts edges until o_valid shows.
  task automatic waitResult(output int lat);
    lat = 0;
    while (!o_valid && lat < 20) begin
      tick;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [4:0] s,
                       input logic [31:0] exp_out, input logic exp_lost, input int stall);
    int lat;
    applyStimulus(a, s);
    waitResult(lat);
    checkOutput({tag, "_latency"}, lat, 5);
    checkOutput({tag, "_out"}, out, exp_out);
    checkOutput({tag, "_lost"}, lost, exp_lost);
    for (int k = 0; k < stall; k++) begin
      tick;
      checkOutput({tag, "_stall_out"}, out, exp_out);
    end
    o_ready = 1'b1;
    tick;
    o_ready = 1'b0;
    checkOutput({tag, "_iready_after"}, i_ready, 1);
  endtask

  initial begin
    int          lat;
    logic        seen_valid;
    int          a0;
    int          r0;
    logic [31:0] ra;
    logic [4:0]  rs;
    logic [31:0] mo;
    logic        ml;

    vecs[0]  = '{32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
    vecs[1]  = '{32'hF000_000F, 5'd4,  32'h0000_00F0, 1'b1};
    vecs[2]  = '{32'h0FFF_FFFF, 5'd4,  32'hFFFF_FFF0, 1'b0};
    vecs[3]  = '{32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1};
    vecs[5]  = '{32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b1};
    vecs[6]  = '{32'h1234_5678, 5'd8,  32'h3456_7800, 1'b1};
    vecs[7]  = '{32'h0000_0003, 5'd30, 32'hC000_0000, 1'b0};
    vecs[8]  = '{32'h0000_0003, 5'd31, 32'h8000_0000, 1'b1};
    vecs[9]  = '{32'hA5A5_A5A5, 5'd16, 32'hA5A5_0000, 1'b1};
    vecs[10] = '{32'h0000_FFFF, 5'd16, 32'hFFFF_0000, 1'b0};
    vecs[11] = '{32'h0000_0000, 5'd13, 32'h0000_0000, 1'b0};

    rst     = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b0;
    in      = '0;
    shamt   = '0;
    tick;
    tick;
    checkOutput("reset_iready", i_ready, 1);
    checkOutput("reset_ovalid", o_valid, 0);
    checkOutput("reset_out", out, 32'h0);
    checkOutput("reset_lost", lost, 0);
    rst = 1'b0;
    tick;
    checkOutput("post_reset_iready", i_ready, 1);

    $display("[TB] directed vector table");
    for (int i = 0; i < 12; i++) begin
      runOp("vec", vecs[i].a, vecs[i].s, vecs[i].exp_out, vecs[i].exp_lost, 0);
    end

    $display("[TB] backpressure sequence");
    applyStimulus(32'hF000_000F, 5'd4);
    waitResult(lat);
    checkOutput("bp_latency", lat, 5);
    in      = 32'h0000_0005;
    shamt   = 5'd2;
    i_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      checkOutput("bp_out", out, 32'h0000_00F0);
      checkOutput("bp_lost", lost, 1);
      checkOutput("bp_iready", i_ready, 0);
      checkOutput("bp_ovalid", o_valid, 1);
    end
    o_ready = 1'b1;
    tick;
    o_ready = 1'b0;
    checkOutput("bp_iready_next", i_ready, 1);
    tick;
    i_valid = 1'b0;
    checkOutput("bp_second_accepted", i_ready, 0);
    waitResult(lat);
    checkOutput("bp2_latency", lat, 5);
    checkOutput("bp2_out", out, 32'h0000_0014);
    checkOutput("bp2_lost", lost, 0);
    o_ready = 1'b1;
    tick;
    o_ready = 1'b0;
    checkOutput("bp2_iready_after", i_ready, 1);

    $display("[TB] reset during stage 2");
    applyStimulus(32'hFFFF_FFFF, 5'd20);
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkOutput("abort_iready", i_ready, 1);
    checkOutput("abort_ovalid", o_valid, 0);
    checkOutput("abort_out", out, 32'h0);
    checkOutput("abort_lost", lost, 0);
    seen_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick;
      seen_valid = seen_valid | o_valid;
    end
    checkOutput("abort_no_valid", seen_valid, 0);
    runOp("after_abort", 32'h1234_5678, 5'd8, 32'h3456_7800, 1'b1, 0);

    $display("[TB] random operands with output stalls");
    a0 = accepts;
    r0 = results;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rs = 5'($urandom_range(0, 31));
      mo = ra << rs;
      ml = (rs != 0) && ((ra >> (32 - int'(rs))) != 0);
      runOp("rand", ra, rs, mo, ml, $urandom_range(0, 3));
    end
    checkOutput("rand_result_count", results - r0, accepts - a0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
